// File: rtl/display_pkg.sv
// Shared types and constant helpers for scanned seven-segment display drivers.
package display_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } slot_state_t;

  // Clock cycles per digit slot.
  function automatic int calc_slot_div(input int fpga_freq, input int refresh_hz, input int seg_cnt);
    return fpga_freq / (refresh_hz * seg_cnt);
  endfunction

  // Clock cycles per PWM step; a slot holds 2^bright_w steps.
  function automatic int calc_pre_div(input int slot_div, input int bright_w);
    return slot_div >> bright_w;
  endfunction

  // XOR mask turning an active-high drive vector into the pin polarity.
  function automatic logic [63:0] pol_mask(input int active_low);
    return (active_low != 0) ? {64{1'b1}} : 64'd0;
  endfunction

endpackage

// File: rtl/display_tick_gen.sv
// Prescaler for scanned displays: step_tick_o pulses once every PRE_DIV cycles (on the wrap).
// No latency beyond the counter itself; free-running, no backpressure.
module display_tick_gen #(
  parameter int PRE_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic step_tick_o,
  output logic pre_zero_o
);

  localparam int              PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q <= '0;
    end else if (pre_q == PRE_MAX) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  assign step_tick_o = (pre_q == PRE_MAX);
  assign pre_zero_o  = (pre_q == '0);

endmodule

// File: rtl/display_mux_pwm.sv
// Scanned 7-seg driver with PWM brightness, per-slot dead time and slot-boundary input shadowing; pins lag scan state by one cycle, free-running.
// Define DISPLAY_MUX_LAMP_TEST_EN to add lamp_test_i (all segments of every digit at full brightness).
module display_mux_pwm
  import display_pkg::*;
#(
  parameter int SEG_CNT        = 4,
  parameter int SEG_W          = 8,
  parameter int FPGA_FREQ      = 50_000_000,
  parameter int REFRESH_HZ     = 1_000,
  parameter int BRIGHT_W       = 4,
  parameter int BLANK_STEPS    = 1,
  parameter int DIG_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [SEG_CNT-1:0]            en_i,
  input  logic [SEG_CNT-1:0][SEG_W-1:0] seg_i,
  input  logic [BRIGHT_W-1:0]           bright_i,
`ifdef DISPLAY_MUX_LAMP_TEST_EN
  input  logic                          lamp_test_i,
`endif
  output logic [SEG_CNT-1:0]            dig_o,
  output logic [SEG_W-1:0]              seg_o,
  output logic [$clog2(SEG_CNT)-1:0]    active_o,
  output logic                          frame_o
);

  localparam int SLOT_DIV = calc_slot_div(FPGA_FREQ, REFRESH_HZ, SEG_CNT);
  localparam int PRE_DIV  = calc_pre_div(SLOT_DIV, BRIGHT_W);
  localparam int ACT_W    = $clog2(SEG_CNT);

  localparam logic [BRIGHT_W-1:0] STEP_MAX  = '1;
  localparam logic [BRIGHT_W-1:0] BLANK_LIM = BRIGHT_W'(BLANK_STEPS);
  localparam logic [ACT_W-1:0]    ACT_MAX   = ACT_W'(SEG_CNT - 1);

  localparam logic [63:0]         DIG_MASK_W = pol_mask(DIG_ACTIVE_LOW);
  localparam logic [63:0]         SEG_MASK_W = pol_mask(SEG_ACTIVE_LOW);
  localparam logic [SEG_CNT-1:0]  DIG_MASK   = DIG_MASK_W[SEG_CNT-1:0];
  localparam logic [SEG_W-1:0]    SEG_MASK   = SEG_MASK_W[SEG_W-1:0];

  if (PRE_DIV < 1) begin : g_bad_pre_div
    $error("display_mux_pwm: clock too slow for REFRESH_HZ*SEG_CNT*2^BRIGHT_W");
  end
  if (BLANK_STEPS >= (1 << BRIGHT_W)) begin : g_bad_blank
    $error("display_mux_pwm: BLANK_STEPS must be below 2^BRIGHT_W");
  end

  logic                step_tick;
  logic                pre_zero;
  logic [BRIGHT_W-1:0] step_q;
  logic [ACT_W-1:0]    active_q;
  logic                slot_start;
  logic                slot_end;

  display_tick_gen #(
    .PRE_DIV (PRE_DIV)
  ) u_tick_gen (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .step_tick_o (step_tick),
    .pre_zero_o  (pre_zero)
  );

  assign slot_start = pre_zero && (step_q == '0);
  assign slot_end   = step_tick && (step_q == STEP_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      step_q   <= '0;
      active_q <= '0;
    end else begin
      if (step_tick) begin
        step_q <= step_q + BRIGHT_W'(1);
      end
      if (slot_end) begin
        active_q <= (active_q == ACT_MAX) ? '0 : active_q + ACT_W'(1);
      end
    end
  end

  // Inputs for the digit owning this slot, with lamp-test overrides applied before shadowing.
  logic                en_raw;
  logic [SEG_W-1:0]    seg_raw;
  logic [BRIGHT_W-1:0] bright_raw;

  always_comb begin
    en_raw     = en_i[active_q];
    seg_raw    = seg_i[active_q];
    bright_raw = bright_i;
`ifdef DISPLAY_MUX_LAMP_TEST_EN
    if (lamp_test_i) begin
      en_raw     = 1'b1;
      seg_raw    = '1;
      bright_raw = STEP_MAX;
    end
`endif
  end

  logic                en_q;
  logic [SEG_W-1:0]    seg_q;
  logic [BRIGHT_W-1:0] bright_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q     <= 1'b0;
      seg_q    <= '0;
      bright_q <= '0;
    end else if (slot_start) begin
      en_q     <= en_raw;
      seg_q    <= seg_raw;
      bright_q <= bright_raw;
    end
  end

  // The slot's first cycle already uses the values being latched into the shadows.
  logic                en_eff;
  logic [SEG_W-1:0]    seg_eff;
  logic [BRIGHT_W-1:0] bright_eff;

  assign en_eff     = slot_start ? en_raw     : en_q;
  assign seg_eff    = slot_start ? seg_raw    : seg_q;
  assign bright_eff = slot_start ? bright_raw : bright_q;

  slot_state_t state_q;
  slot_state_t state_d;

  always_comb begin
    state_d = state_q;
    if (slot_start) begin
      if (BLANK_LIM != '0) begin
        state_d = BLANK;
      end else if (bright_eff != '0) begin
        state_d = ON;
      end else begin
        state_d = OFF;
      end
    end else begin
      unique case (state_q)
        BLANK: begin
          if (step_q >= BLANK_LIM) begin
            state_d = (step_q < bright_eff) ? ON : OFF;
          end
        end
        ON: begin
          if (step_q >= bright_eff) begin
            state_d = OFF;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  logic               lit_d;
  logic [SEG_CNT-1:0] dig_d;
  logic [SEG_W-1:0]   seg_d;

  assign lit_d = (state_d == ON) && en_eff;
  assign dig_d = lit_d ? (SEG_CNT'(1) << active_q) : '0;
  assign seg_d = lit_d ? seg_eff : '0;

  // frame_pend_q marks the first scan cycle of digit 0 after a wrap, so no pulse follows reset.
  logic frame_pend_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= BLANK;
      dig_o        <= DIG_MASK;
      seg_o        <= SEG_MASK;
      active_o     <= '0;
      frame_pend_q <= 1'b0;
      frame_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_o        <= dig_d ^ DIG_MASK;
      seg_o        <= seg_d ^ SEG_MASK;
      active_o     <= active_q;
      frame_pend_q <= slot_end && (active_q == ACT_MAX);
      frame_o      <= frame_pend_q;
    end
  end

endmodule

// File: tb/tb_display_mux_pwm.sv
// Bench for display_mux_pwm: active-high and active-low instances checked every cycle against a slot-level model.
module tb_display_mux_pwm;

  localparam int SEG_CNT     = 4;
  localparam int SEG_W       = 8;
  localparam int BRIGHT_W    = 4;
  localparam int BLANK_STEPS = 1;
  localparam int FPGA_FREQ   = 64_000;
  localparam int REFRESH_HZ  = 1000;
  localparam int STEPS       = 1 << BRIGHT_W;
  localparam int PRE         = FPGA_FREQ / (REFRESH_HZ * SEG_CNT) / STEPS;
  localparam int SLOT        = PRE * STEPS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [SEG_CNT-1:0]            en;
  logic [SEG_CNT-1:0][SEG_W-1:0] seg;
  logic [BRIGHT_W-1:0]           bright;

  logic [SEG_CNT-1:0] dig_h, dig_l;
  logic [SEG_W-1:0]   seg_h, seg_l;
  logic [1:0]         act_h, act_l;
  logic               frame_h, frame_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_mux_pwm #(
    .SEG_CNT(SEG_CNT), .SEG_W(SEG_W), .FPGA_FREQ(FPGA_FREQ), .REFRESH_HZ(REFRESH_HZ),
    .BRIGHT_W(BRIGHT_W), .BLANK_STEPS(BLANK_STEPS), .DIG_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_h (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .seg_i(seg), .bright_i(bright),
    .dig_o(dig_h), .seg_o(seg_h), .active_o(act_h), .frame_o(frame_h)
  );

  display_mux_pwm #(
    .SEG_CNT(SEG_CNT), .SEG_W(SEG_W), .FPGA_FREQ(FPGA_FREQ), .REFRESH_HZ(REFRESH_HZ),
    .BRIGHT_W(BRIGHT_W), .BLANK_STEPS(BLANK_STEPS), .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_l (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .seg_i(seg), .bright_i(bright),
    .dig_o(dig_l), .seg_o(seg_l), .active_o(act_l), .frame_o(frame_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [SEG_CNT-1:0] e_dig, input logic [SEG_W-1:0] e_seg,
                           input logic [1:0] e_act, input logic e_frame);
    logic [SEG_CNT-1:0] inv_dig;
    logic [SEG_W-1:0]   inv_seg;
    inv_dig = ~e_dig;
    inv_seg = ~e_seg;
    check("dig",     dig_h,   e_dig);
    check("seg",     seg_h,   e_seg);
    check("active",  act_h,   e_act);
    check("frame",   frame_h, e_frame);
    check("dig_n",   dig_l,   inv_dig);
    check("seg_n",   seg_l,   inv_seg);
    check("active_n", act_l,  e_act);
    check("frame_n", frame_l, e_frame);
  endtask

  // Model: scan index k since reset -> slot position, digit, step; pins show scan state k-1.
  int                 k;
  bit                 have_prev;
  int                 pos, stp, a, m_br;
  bit                 m_en, lit;
  logic [SEG_W-1:0]   m_seg;
  logic [SEG_CNT-1:0] x_dig;
  logic [SEG_W-1:0]   x_seg;
  logic [1:0]         x_act;
  logic               x_frame;

  initial begin : model
    k = 0;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_all('0, '0, 2'd0, 1'b0);
        k = 0;
        have_prev = 0;
      end else begin
        if (have_prev) check_all(x_dig, x_seg, x_act, x_frame);
        else           check_all('0, '0, 2'd0, 1'b0);
        pos = k % SLOT;
        stp = pos / PRE;
        a   = (k / SLOT) % SEG_CNT;
        if (pos == 0) begin
          m_en  = en[a];
          m_seg = seg[a];
          m_br  = int'(bright);
        end
        lit     = m_en && (stp >= BLANK_STEPS) && (stp < m_br);
        x_dig   = lit ? (4'b0001 << a) : 4'b0000;
        x_seg   = lit ? m_seg : 8'h00;
        x_act   = a[1:0];
        x_frame = (pos == 0) && (a == 0) && (k > 0);
        have_prev = 1;
        k++;
      end
    end
  end

  int lit_cnt [SEG_CNT];
  int frames;
  int segs_on;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic observe(input int n);
    for (int d = 0; d < SEG_CNT; d++) lit_cnt[d] = 0;
    frames  = 0;
    segs_on = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < SEG_CNT; d++)
        if (dig_h[d] && $countones(dig_h) == 1) lit_cnt[d]++;
      if (frame_h) frames++;
      if (seg_h != '0) segs_on++;
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (frame_h) ok = 1;
    end
  endtask

  task automatic frame_gap(output int gap);
    bit ok;
    gap = -1;
    wait_frame(ok);
    if (ok) begin
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (frame_h) begin
          gap = i;
          break;
        end
      end
    end
  endtask

  initial begin : stim
    bit ok;
    int gap;
    int n;

    en     = 4'hF;
    seg    = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    bright = 4'd15;
    rst_n  = 1'b0;
    idle(3);
    check("rst_dig",    dig_h, 4'h0);
    check("rst_seg",    seg_h, 8'h00);
    check("rst_dig_n",  dig_l, 4'hF);
    check("rst_seg_n",  seg_l, 8'hFF);
    check("rst_active", act_h, 2'd0);
    check("rst_frame",  frame_h, 1'b0);
    rst_n = 1'b1;

    // Scenario 1: full brightness, all digits, known pattern
    @(negedge clk);
    check("start_out_dig", dig_h, 4'h0);
    @(negedge clk);
    check("step0_blank_dig", dig_h, 4'h0);
    @(negedge clk);
    check("d0_step1_dig",   dig_h, 4'b0001);
    check("d0_step1_seg",   seg_h, 8'h3F);
    check("d0_step1_dig_n", dig_l, 4'hE);
    check("d0_step1_seg_n", seg_l, 8'hC0);
    observe(64);
    for (int d = 0; d < SEG_CNT; d++) check("lit15_cycles", lit_cnt[d], 14);
    check("frames_per_64", frames, 1);
    frame_gap(gap);
    check("frame_period", gap, 64);

    // Scenario 2: reduced and minimal brightness
    idle(1);
    bright = 4'd8;
    idle(80);
    observe(64);
    for (int d = 0; d < SEG_CNT; d++) check("lit8_cycles", lit_cnt[d], 7);
    idle(1);
    bright = 4'd1;
    idle(80);
    observe(64);
    check("lit1_d0", lit_cnt[0], 0);
    check("lit1_seg_on", segs_on, 0);
    idle(1);
    bright = 4'd0;
    idle(80);
    observe(64);
    check("lit0_d1", lit_cnt[1], 0);
    check("lit0_seg_on", segs_on, 0);

    // Scenario 3: sparse enables
    idle(1);
    bright = 4'd15;
    en     = 4'b0101;
    idle(80);
    observe(64);
    check("en_d0", lit_cnt[0], 14);
    check("en_d1", lit_cnt[1], 0);
    check("en_d2", lit_cnt[2], 14);
    check("en_d3", lit_cnt[3], 0);
    check("en_frames", frames, 1);
    frame_gap(gap);
    check("en_frame_period", gap, 64);

    // Scenario 4: mid-slot pattern change is deferred to the next frame
    idle(1);
    en = 4'hF;
    idle(80);
    wait_frame(ok);
    check("frame_found_a", ok, 1'b1);
    n = 0;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #2;
      if (i == 4) seg[0] = 8'h00;
      @(negedge clk);
      if (dig_h == 4'b0001 && seg_h == 8'h3F) n++;
    end
    check("hold_old_seg", n, 14);
    wait_frame(ok);
    check("frame_found_b", ok, 1'b1);
    n = 0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (dig_h == 4'b0001 && seg_h == 8'h00) n++;
    end
    check("new_seg_next_frame", n, 14);
    idle(1);
    seg[0] = 8'h3F;

    // Scenario 6: reset at step 7 of digit 2
    idle(80);
    wait_frame(ok);
    check("frame_found_c", ok, 1'b1);
    repeat (37) @(posedge clk);
    @(negedge clk);
    check("pre_rst_d2", dig_h, 4'b0100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dig",   dig_h, 4'h0);
    check("async_rst_seg",   seg_h, 8'h00);
    check("async_rst_dig_n", dig_l, 4'hF);
    check("async_rst_seg_n", seg_l, 8'hFF);
    check("async_rst_act",   act_h, 2'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_step0", dig_h, 4'h0);
    @(negedge clk);
    check("restart_d0_dig", dig_h, 4'b0001);
    check("restart_d0_act", act_h, 2'd0);

    // Random inputs with occasional resets
    for (int i = 0; i < 2000; i++) begin
      idle(1);
      if ($urandom_range(0, 7) == 0) en = SEG_CNT'($urandom);
      if ($urandom_range(0, 7) == 0) seg[$urandom_range(0, SEG_CNT - 1)] = SEG_W'($urandom);
      if ($urandom_range(0, 15) == 0) bright = BRIGHT_W'($urandom_range(0, STEPS - 1));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
